// File: rtl/uart_hex_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_hex_rx
// Brief    : 8N1 UART receiver that pairs ASCII hex digits into bytes and
//            buffers them in a show-ahead FIFO read with rd/empty.
// Revision : 1.0 - initial release
// ============================================================================
module uart_hex_rx #(
    parameter int DVSR    = 163,
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_W  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic       rd,
    output logic [7:0] byte_rx,
    output logic       empty,
    output logic       full,
    output logic       bad_char,
    output logic       frame_err,
    output logic       overflow
);

    localparam int c_TICK_W = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int c_N_W    = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int c_DEPTH  = 1 << FIFO_W;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(DVSR - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [c_N_W-1:0]    c_N_LAST    = c_N_W'(DBIT - 1);
    localparam logic [c_N_W-1:0]    c_N_ONE     = c_N_W'(1);
    localparam logic [3:0]          c_S_STOP    = 4'(SB_TICK - 1);
    localparam logic [FIFO_W:0]     c_PTR_ONE   = (FIFO_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer and oversampling tick
    // ------------------------------------------------------------------
    logic                r_sync1;
    logic                r_sync2;
    logic                w_rx;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx   = r_sync2;
    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_s;
    logic [3:0]       w_s_nxt;
    logic [c_N_W-1:0] r_n;
    logic [c_N_W-1:0] w_n_nxt;
    logic [DBIT-1:0]  r_b;
    logic [DBIT-1:0]  w_b_nxt;
    logic             w_stop_hit;
    logic             w_char_done;
    logic             w_frame_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_s     <= 4'd0;
            r_n     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_b_nxt     = r_b;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx) begin
                    w_state_nxt = ST_START;
                    w_s_nxt     = 4'd0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_s == 4'd7) begin
                        w_state_nxt = ST_DATA;
                        w_s_nxt     = 4'd0;
                        w_n_nxt     = '0;
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_s == 4'd15) begin
                        w_b_nxt = {w_rx, r_b[DBIT-1:1]};
                        w_s_nxt = 4'd0;
                        if (r_n == c_N_LAST) begin
                            w_state_nxt = ST_STOP;
                        end else begin
                            w_n_nxt = r_n + c_N_ONE;
                        end
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_s == c_S_STOP) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pulses are masked while reset is held so they read 0 in reset.
    assign w_stop_hit  = reset && (r_state == ST_STOP) && w_tick && (r_s == c_S_STOP);
    assign w_char_done = w_stop_hit && w_rx;
    assign w_frame_err = w_stop_hit && !w_rx;

    // ------------------------------------------------------------------
    // ASCII hex decoder
    // ------------------------------------------------------------------
    logic [7:0] w_char;
    logic       w_is_hex;
    logic       w_is_sep;
    logic [3:0] w_nib;
    logic       r_have_hi;
    logic [3:0] r_hi;
    logic       w_wr;
    logic [7:0] w_wr_data;

    assign w_char = 8'(r_b);

    always_comb begin
        w_is_hex = 1'b0;
        w_is_sep = 1'b0;
        w_nib    = 4'h0;
        if ((w_char >= 8'h30) && (w_char <= 8'h39)) begin
            w_is_hex = 1'b1;
            w_nib    = 4'(w_char - 8'h30);
        end else if ((w_char >= 8'h41) && (w_char <= 8'h46)) begin
            w_is_hex = 1'b1;
            w_nib    = 4'(w_char - 8'h37);
        end else if ((w_char >= 8'h61) && (w_char <= 8'h66)) begin
            w_is_hex = 1'b1;
            w_nib    = 4'(w_char - 8'h57);
        end else if ((w_char == 8'h20) || (w_char == 8'h0D) || (w_char == 8'h0A)) begin
            w_is_sep = 1'b1;
        end
    end

    assign w_wr      = w_char_done && w_is_hex && r_have_hi;
    assign w_wr_data = {r_hi, w_nib};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_have_hi <= 1'b0;
            r_hi      <= 4'h0;
        end else if (w_frame_err) begin
            r_have_hi <= 1'b0;
        end else if (w_char_done) begin
            if (w_is_hex && !r_have_hi) begin
                r_have_hi <= 1'b1;
                r_hi      <= w_nib;
            end else begin
                r_have_hi <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO; pointer MSB is the wrap bit
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [c_DEPTH];
    logic [FIFO_W:0] r_wptr;
    logic [FIFO_W:0] r_rptr;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[FIFO_W] != r_rptr[FIFO_W]) &&
                     (r_wptr[FIFO_W-1:0] == r_rptr[FIFO_W-1:0]);
    assign w_pop   = rd && !w_empty;
    // A full FIFO still takes the write when the head is popped on the same edge.
    assign w_push  = w_wr && (!w_full || rd);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[FIFO_W-1:0]] <= w_wr_data;
        end
    end

    assign byte_rx   = w_empty ? 8'h00 : r_mem[r_rptr[FIFO_W-1:0]];
    assign empty     = w_empty;
    assign full      = w_full;
    assign bad_char  = w_char_done && !w_is_hex && !w_is_sep;
    assign frame_err = w_frame_err;
    assign overflow  = w_wr && w_full && !rd;

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_hex_rx
// Brief    : Scoreboard bench for uart_hex_rx with directed character vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_hex_rx;

    localparam int DVSR     = 4;
    localparam int BIT_CLKS = 16 * DVSR;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       uart_rx  = 1'b1;
    logic       force_rd = 1'b0;
    logic       auto_rd  = 1'b0;
    logic       auto_pop = 1'b0;
    logic       rd;
    logic [7:0] byte_rx;
    logic       empty;
    logic       full;
    logic       bad_char;
    logic       frame_err;
    logic       overflow;

    assign rd = force_rd | auto_pop;

    uart_hex_rx #(
        .DVSR    (DVSR),
        .DBIT    (8),
        .SB_TICK (16),
        .FIFO_W  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rd        (rd),
        .byte_rx   (byte_rx),
        .empty     (empty),
        .full      (full),
        .bad_char  (bad_char),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         n_bad = 0, n_ferr = 0, n_ovf = 0;
    int         e_bad = 0, e_ferr = 0, e_ovf = 0;
    logic       p_bad = 1'b0, p_ferr = 1'b0, p_ovf = 1'b0;
    int         start_cyc = -1;
    int         lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Automatic reader: requests a pop for every cycle the FIFO shows data.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            auto_pop = auto_rd && (empty == 1'b0);
        end
    end

    // Monitor: every accepted pop is compared with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (rd && !empty) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pop: got byte %02h, required none", byte_rx);
                    end else begin
                        check("byte_rx", {24'd0, byte_rx}, {24'd0, exp_q.pop_front()});
                    end
                end
                if (bad_char) begin
                    n_bad++;
                    check("bad_char_width", {31'd0, p_bad}, 32'd0);
                end
                if (frame_err) begin
                    n_ferr++;
                    check("frame_err_width", {31'd0, p_ferr}, 32'd0);
                end
                if (overflow) begin
                    n_ovf++;
                    check("overflow_width", {31'd0, p_ovf}, 32'd0);
                end
            end
            p_bad  = bad_char;
            p_ferr = frame_err;
            p_ovf  = overflow;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c, input bit stop_ok);
        do begin
            @(posedge clk);
            #1;
        end while (cyc % DVSR != 0);
        start_cyc = cyc;
        uart_rx   = 1'b0;
        hold(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = c[i];
            hold(BIT_CLKS);
        end
        uart_rx = stop_ok;
        hold(BIT_CLKS);
        uart_rx = 1'b1;
        hold(8);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && empty) break;
            hold(1);
        end
        check({tag, "_pending"}, exp_q.size(), 32'd0);
        check({tag, "_empty"}, {31'd0, empty}, 32'd1);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_bad_char_cnt"}, n_bad, e_bad);
        check({tag, "_frame_err_cnt"}, n_ferr, e_ferr);
        check({tag, "_overflow_cnt"}, n_ovf, e_ovf);
    endtask

    initial begin
        // Reset held for three edges with an idle line.
        reset   = 1'b0;
        uart_rx = 1'b1;
        hold(3);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_byte_rx", {24'd0, byte_rx}, 32'h00);
        check("rst_bad_char", {31'd0, bad_char}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b1;
        hold(4);

        // Reset mid-frame: '4' is pending and '2' is cut off half way.
        auto_rd = 1'b1;
        send_char("4", 1'b1);
        do begin
            @(posedge clk);
            #1;
        end while (cyc % DVSR != 0);
        uart_rx = 1'b0;
        hold(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            uart_rx = 8'h32 >> i;
            hold(BIT_CLKS);
        end
        reset   = 1'b0;
        uart_rx = 1'b1;
        hold(3);
        reset = 1'b1;
        hold(700);
        check("midrst_empty", {31'd0, empty}, 32'd1);
        check_counts("midrst");

        // Basic byte; also measures start-bit-to-write latency.
        auto_rd = 1'b0;
        hold(2);
        exp_q.push_back(8'h41);
        send_char("4", 1'b1);
        start_cyc = -1;
        lat       = 0;
        fork
            send_char("1", 1'b1);
            begin
                wait (start_cyc >= 0);
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk);
                    if (!empty) begin
                        lat = cyc - start_cyc;
                        break;
                    end
                end
            end
        join
        check("basic_empty_low", {31'd0, empty}, 32'd0);
        check("basic_head", {24'd0, byte_rx}, 32'h41);
        if (lat <= 0) begin
            checks++;
            failures++;
            $display("FAIL basic_latency: got no write, required one within 1000 cycles");
            lat = 608;
        end
        force_rd = 1'b1;
        hold(1);
        force_rd = 1'b0;
        hold(1);
        check("basic_empty_after_rd", {31'd0, empty}, 32'd1);
        check_counts("basic");

        // Case handling.
        auto_rd = 1'b1;
        exp_q.push_back(8'hAF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h09);
        send_str("aFff09");
        drain("case");
        check_counts("case");

        // Separators split a pair; a non-hex code pulses bad_char.
        exp_q.push_back(8'h7E);
        send_str("3 7E");
        drain("sep");
        check_counts("sep");
        send_str("G");
        e_bad++;
        hold(20);
        check("badchar_empty", {31'd0, empty}, 32'd1);
        check_counts("badchar");

        // Overflow with no reads: 0x05 is dropped.
        auto_rd = 1'b0;
        hold(2);
        for (int v = 1; v <= 5; v++) begin
            if (v <= 4) exp_q.push_back(8'(v));
            send_str($sformatf("%02X", v));
            if (v == 4) check("ovf_full_at4", {31'd0, full}, 32'd1);
        end
        e_ovf++;
        check("ovf_full_at5", {31'd0, full}, 32'd1);
        check_counts("ovf");
        auto_rd = 1'b1;
        drain("ovf");

        // Overflow case with a pop on the write edge: 0x05 is kept.
        auto_rd = 1'b0;
        hold(2);
        for (int v = 1; v <= 4; v++) begin
            exp_q.push_back(8'(v));
            send_str($sformatf("%02X", v));
        end
        check("ovfrd_full_at4", {31'd0, full}, 32'd1);
        exp_q.push_back(8'h05);
        send_char("0", 1'b1);
        start_cyc = -1;
        fork
            send_char("5", 1'b1);
            begin
                wait (start_cyc >= 0);
                while (cyc < start_cyc + lat - 1) begin
                    @(posedge clk);
                    #1;
                end
                force_rd = 1'b1;
                @(posedge clk);
                #1;
                force_rd = 1'b0;
            end
        join
        check("ovfrd_full_after", {31'd0, full}, 32'd1);
        check_counts("ovfrd");
        auto_rd = 1'b1;
        drain("ovfrd");

        // Framing error drops the pending '5'. The line is still low when
        // the receiver returns to idle, so it also sees an all-ones character.
        send_char("5", 1'b1);
        send_char(8'h35, 1'b0);
        e_ferr++;
        e_bad++;
        hold(800);
        exp_q.push_back(8'h66);
        send_str("66");
        drain("ferr");
        check_counts("ferr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
